// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the memory-access stage
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // size is funct3[1:0]: 00 byte, 01 half, anything else is a word access
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_formatter.sv
// rtl/mem_load_formatter.sv - lane select and sign/zero extension of a load word
module mem_load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory access, load formatting, MEM/WB register
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [XLEN-1:0] ex_pc_plus4,
    input  logic [4:0]      ex_rd_addr,
    input  logic            ex_reg_write_en,
    input  logic [1:0]      ex_mem_to_reg,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_load_data,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_reg_write_en,
    output logic [1:0]      wb_mem_to_reg,
    output logic            misalign_err,
    output logic            bus_err
);

    mem_state_e      state_q;
    logic [31:0]     tmo_cnt_q, tmo_cnt_d;
    logic [XLEN-1:0] cap_res_q;
    logic [4:0]      cap_rd_q;
    logic            cap_we_q;
    logic [1:0]      cap_m2r_q;
    logic            cap_load_q;
    logic [2:0]      cap_f3_q;
    logic [1:0]      cap_lane_q;

    logic            is_mem, misal;
    logic [1:0]      lane;
    logic [XLEN-1:0] res_sel, st_wdata, fmt_data;
    logic [3:0]      st_be;

    assign ex_ready = (state_q == IDLE);

    always_comb begin
        is_mem    = ex_mem_read | ex_mem_write;
        lane      = ex_alu_result[1:0];
        misal     = is_misaligned(ex_funct3[1:0], lane);
        res_sel   = (ex_mem_to_reg == WB_SEL_PC4) ? ex_pc_plus4 : ex_alu_result;
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        // Stores replicate data across lanes so memory only needs the byte enables
        case (ex_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << lane;
                st_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {lane[1], 1'b0};
                st_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = ex_store_data;
            end
        endcase
    end

    mem_load_formatter u_fmt (
        .rdata_i  (dmem_rdata),
        .lane_i   (cap_lane_q),
        .funct3_i (cap_f3_q),
        .data_o   (fmt_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            tmo_cnt_q       <= '0;
            cap_res_q       <= '0;
            cap_rd_q        <= '0;
            cap_we_q        <= 1'b0;
            cap_m2r_q       <= '0;
            cap_load_q      <= 1'b0;
            cap_f3_q        <= '0;
            cap_lane_q      <= '0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            dmem_be         <= '0;
            wb_valid        <= 1'b0;
            wb_alu_result   <= '0;
            wb_load_data    <= '0;
            wb_rd_addr      <= '0;
            wb_reg_write_en <= 1'b0;
            wb_mem_to_reg   <= '0;
            misalign_err    <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid && is_mem && !misal) begin
                        state_q    <= WAIT;
                        tmo_cnt_q  <= '0;
                        cap_res_q  <= res_sel;
                        cap_rd_q   <= ex_rd_addr;
                        cap_we_q   <= ex_reg_write_en && (ex_rd_addr != 5'd0);
                        cap_m2r_q  <= ex_mem_to_reg;
                        cap_load_q <= ex_mem_read;
                        cap_f3_q   <= ex_funct3;
                        cap_lane_q <= lane;
                        dmem_req   <= 1'b1;
                        dmem_we    <= ex_mem_write && !ex_mem_read;
                        dmem_addr  <= {ex_alu_result[XLEN-1:2], 2'b00};
                        dmem_wdata <= st_wdata;
                        dmem_be    <= st_be;
                    end else if (ex_valid) begin
                        wb_valid        <= 1'b1;
                        wb_alu_result   <= res_sel;
                        wb_load_data    <= '0;
                        wb_rd_addr      <= ex_rd_addr;
                        wb_mem_to_reg   <= ex_mem_to_reg;
                        wb_reg_write_en <= ex_reg_write_en && (ex_rd_addr != 5'd0) && !(is_mem && misal);
                        misalign_err    <= is_mem && misal;
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        state_q         <= IDLE;
                        tmo_cnt_q       <= '0;
                        dmem_req        <= 1'b0;
                        dmem_we         <= 1'b0;
                        wb_valid        <= 1'b1;
                        wb_alu_result   <= cap_res_q;
                        wb_load_data    <= cap_load_q ? fmt_data : '0;
                        wb_rd_addr      <= cap_rd_q;
                        wb_mem_to_reg   <= cap_m2r_q;
                        wb_reg_write_en <= cap_we_q;
                    end else if (DMEM_TIMEOUT != 0 && tmo_cnt_d == DMEM_TIMEOUT) begin
                        state_q         <= IDLE;
                        tmo_cnt_q       <= '0;
                        dmem_req        <= 1'b0;
                        dmem_we         <= 1'b0;
                        wb_valid        <= 1'b1;
                        wb_alu_result   <= cap_res_q;
                        wb_load_data    <= '0;
                        wb_rd_addr      <= cap_rd_q;
                        wb_mem_to_reg   <= cap_m2r_q;
                        wb_reg_write_en <= 1'b0;
                        bus_err         <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
